// File: rtl/cam_pattern_gen.sv
// Synthetic camera source: emits DVP-style vsync/href/data frames carrying one of
// four test patterns, with frame counting and a done pulse on the last pixel beat.
module cam_pattern_gen #(
    parameter int HRES        = 640,
    parameter int VRES        = 480,
    parameter int DATA_W      = 8,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10,
    parameter int HBLANK      = 144
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    output logic              cam_vsync_o,
    output logic              cam_href_o,
    output logic [DATA_W-1:0] cam_data_o,
    output logic [15:0]       frame_cnt_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int BPC       = (DATA_W == 8) ? 2 : 1;
    localparam int BEAT_SH   = (DATA_W == 8) ? 1 : 0;
    localparam int TLINE     = HRES * BPC + HBLANK;
    localparam int MAX_LINES = (VSYNC_LINES > VBP_LINES)
                               ? ((VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES)
                               : ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);
    localparam int CNT_MAX   = MAX_LINES * TLINE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int LN_W      = (VRES > 1) ? $clog2(VRES) : 1;
    localparam int BAR_DIV   = HRES / 8;

    localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(VSYNC_LINES * TLINE - 1);
    localparam logic [CNT_W-1:0] VBP_LAST   = CNT_W'(VBP_LINES * TLINE - 1);
    localparam logic [CNT_W-1:0] VFP_LAST   = CNT_W'(VFP_LINES * TLINE - 1);
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(HRES * BPC - 1);
    localparam logic [CNT_W-1:0] HBL_LAST   = CNT_W'(HBLANK - 1);
    localparam logic [LN_W-1:0]  LAST_LINE  = LN_W'(VRES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_LINE,
        S_HBL,
        S_VFP
    } state_t;

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [LN_W-1:0]   r_line, w_line_next;
    logic [1:0]        r_mode, w_mode_next;
    logic [15:0]       r_fcnt, w_fcnt_next;
    logic              w_frame_done;

    logic              w_href;
    logic [31:0]       w_col;
    logic [31:0]       w_line32;
    logic [2:0]        w_bar;
    logic [15:0]       w_pix;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_mode  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_line  <= w_line_next;
            r_mode  <= w_mode_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // r_cnt counts cycles spent in the current state and clears on every transition.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_line_next  = r_line;
        w_mode_next  = r_mode;
        w_fcnt_next  = r_fcnt;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_line_next = '0;
                if (enable_i) begin
                    w_state_next = S_VSYNC;
                    w_mode_next  = mode_i;
                end
            end
            S_VSYNC: begin
                if (r_cnt == VSYNC_LAST) begin
                    w_state_next = S_VBP;
                    w_cnt_next   = '0;
                end
            end
            S_VBP: begin
                if (r_cnt == VBP_LAST) begin
                    w_state_next = S_LINE;
                    w_cnt_next   = '0;
                    w_line_next  = '0;
                end
            end
            S_LINE: begin
                if (r_cnt == LINE_LAST) begin
                    w_state_next = S_HBL;
                    w_cnt_next   = '0;
                    if (r_line == LAST_LINE) begin
                        w_frame_done = 1'b1;
                        w_fcnt_next  = r_fcnt + 16'd1;
                    end
                end
            end
            S_HBL: begin
                if (r_cnt == HBL_LAST) begin
                    w_cnt_next = '0;
                    if (r_line == LAST_LINE) begin
                        w_state_next = S_VFP;
                        w_line_next  = '0;
                    end else begin
                        w_state_next = S_LINE;
                        w_line_next  = r_line + 1'b1;
                    end
                end
            end
            S_VFP: begin
                if (r_cnt == VFP_LAST) begin
                    w_cnt_next = '0;
                    if (enable_i) begin
                        w_state_next = S_VSYNC;
                        w_mode_next  = mode_i;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_line_next  = '0;
            end
        endcase
    end

    assign w_href   = (r_state == S_LINE);
    assign w_col    = 32'(r_cnt) >> BEAT_SH;
    assign w_line32 = 32'(r_line);
    assign w_bar    = 3'(w_col / 32'(BAR_DIV));

    always_comb begin
        w_pix = '0;
        case (r_mode)
            2'd0: w_pix = {{5{w_bar[2]}}, {6{w_bar[1]}}, {5{w_bar[0]}}};
            2'd1: w_pix = 16'(w_line32 * 32'(HRES) + w_col);
            2'd2: w_pix = {w_line32[7:0], w_col[7:0]};
            default: w_pix = {r_fcnt[7:0], r_fcnt[7:0]};
        endcase
    end

    // Narrow bus sends the high byte on the even beat, low byte on the odd beat.
    generate
        if (DATA_W == 8) begin : g_byte
            logic w_beat;
            assign w_beat     = r_cnt[0];
            assign cam_data_o = w_href ? (w_beat ? w_pix[7:0] : w_pix[15:8]) : '0;
        end else begin : g_word
            assign cam_data_o = w_href ? DATA_W'(w_pix) : '0;
        end
    endgenerate

    assign cam_vsync_o  = (r_state == S_VSYNC);
    assign cam_href_o   = w_href;
    assign frame_cnt_o  = r_fcnt;
    assign frame_done_o = w_frame_done;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: doc/cam_pattern_gen.md
CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 SHALL have parameter HRES, default 640, active pixels per line (>=8, multiple of 8).
REQ-002 SHALL have parameter VRES, default 480, active lines per frame (>=1).
REQ-003 SHALL have parameter DATA_W, default 8, output bus width (8 or 16 only).
REQ-004 SHALL have parameters VSYNC_LINES=3, VBP_LINES=17, VFP_LINES=10 (each >=1), all in line times.
REQ-005 SHALL have parameter HBLANK, default 144, blanking cycles after each active line (>=1).
REQ-006 SHALL have port clk_i, input, 1, sole clock; all outputs change only on its rising edge.
REQ-007 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port enable_i, input, 1, request frame streaming.
REQ-009 SHALL have port mode_i, input, 2, pattern select.
REQ-010 SHALL have port cam_vsync_o, output, 1, frame sync (active high).
REQ-011 SHALL have port cam_href_o, output, 1, line valid.
REQ-012 SHALL have port cam_data_o, output, DATA_W, pixel data.
REQ-013 SHALL have port frame_cnt_o, output, 16, completed-frame count.
REQ-014 SHALL have port frame_done_o, output, 1, one-cycle pulse per completed frame.
REQ-015 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL define BPC (beats per pixel) = 2 when DATA_W=8, 1 when DATA_W=16; TLINE = HRES*BPC + HBLANK cycles.
REQ-017 SHALL implement states IDLE, VSYNC, VBP, LINE, HBL, VFP.
REQ-018 SHALL move IDLE->VSYNC on the edge where enable_i=1; mode_i sampled and held for the whole frame on that edge.
REQ-019 SHALL hold VSYNC for exactly VSYNC_LINES*TLINE cycles with cam_vsync_o=1, then VBP for VBP_LINES*TLINE cycles.
REQ-020 SHALL per active line: LINE for HRES*BPC cycles with cam_href_o=1, then HBL for HBLANK cycles with cam_href_o=0; repeated VRES times.
REQ-021 SHALL after the last HBL spend VFP_LINES*TLINE cycles in VFP, then go to VSYNC if enable_i=1 (re-sampling mode_i) else IDLE.
REQ-022 SHALL drive cam_data_o=0 whenever cam_href_o=0.
REQ-023 SHALL produce 16-bit pixel P(col,line) per mode: 0 = colour bars, bar b=col*8/HRES, P={5{b[2]},6{b[1]},5{b[0]}}; 1 = P=(line*HRES+col) mod 2^16; 2 = P={line[7:0],col[7:0]}; 3 = P={frame_cnt_o[7:0],frame_cnt_o[7:0]}.
REQ-024 SHALL with DATA_W=8 send P[15:8] on the first beat and P[7:0] on the second; with DATA_W=16 send P each cycle.
REQ-025 SHALL pulse frame_done_o for one cycle on the final LINE beat of line VRES-1, and increment frame_cnt_o on that same edge, wrapping 0xFFFF->0x0000.
REQ-026 SHALL ignore enable_i deassertion mid-frame; the current frame completes including VFP before IDLE.
REQ-027 SHALL ignore mode_i changes except at the sampling edges of REQ-018/REQ-021.
REQ-028 SHALL use internal counters wide enough for the largest of (VBP_LINES, VFP_LINES, VSYNC_LINES)*TLINE without overflow.

Reset
REQ-029 SHALL on rst_i=1 immediately force IDLE and cam_vsync_o=0, cam_href_o=0, cam_data_o=0, frame_cnt_o=0, frame_done_o=0, busy_o=0, all counters 0.
REQ-030 SHALL on rst_i asserted mid-frame abort the frame with no frame_done_o pulse; after release the next frame starts from VSYNC with col=line=0.

Verification (HRES=8, VRES=2, DATA_W=8, VSYNC_LINES=VBP_LINES=VFP_LINES=1, HBLANK=2, TLINE=18)
REQ-031 SHALL check: enable_i=1 held, mode 0 -> vsync 18 cycles, 18 low, href 16 high/2 low twice, 18 VFP, next vsync; bytes 00,00,00,1F,07,E0,07,FF,F8,00,F8,1F,FF,E0,FF,FF.
REQ-032 SHALL check: mode 1 -> line 1 bytes 00,08,00,09,...,00,0F; frame_done_o one pulse on last href beat; frame_cnt_o 0->1.
REQ-033 SHALL check: enable_i dropped during line 0 -> frame completes, busy_o falls after VFP, outputs 0, frame_cnt_o=1.
REQ-034 SHALL check: mode_i changed 0->3 mid-frame -> current frame stays colour bars; next frame bytes all 01 (frame_cnt_o=1).
REQ-035 SHALL check: rst_i pulsed during line 1 -> outputs 0 asynchronously, no frame_done_o, frame_cnt_o=0; restart gives full 18-cycle vsync.
REQ-036 SHALL check: DATA_W=16, mode 2 -> href high 8 cycles per line, line 1 words 0x0100..0x0107.
